fetch_stage: RTL and testbench

Instruction fetch stage of the hotate RV32 core. It owns the program counter, drives the instruction-memory address port, and captures the instruction word that the synchronous instruction ROM returns one cycle later. It presents {pc, inst} pairs to decode through a valid/ready handshake, with a 2-entry output buffer so that downstream stalls never lose a word. It accepts a redirect (branch/jump/trap target) that flushes all buffered and in-flight fetches.

---
 rtl/fetch_if.sv | 28 ++
 rtl/fetch_stage.sv | 96 +++++++++
 tb/tb_fetch_stage.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// fetch_if: bundles the instruction-memory port, the redirect request and
// the {pc, inst} output handshake of the fetch stage.
//   imem_addr      fetch -> ROM      byte address, driven every cycle
//   imem_inst      ROM   -> fetch    word for the previous cycle's address
//   redirect_valid/redirect_pc       new fetch target, flushes the stage
//   out_valid/out_ready              decode handshake
//   out_pc/out_inst                  head instruction and its address
// master = fetch stage side, slave = ROM/decode/redirect environment side.
interface fetch_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    modport master (
        output imem_addr, out_valid, out_pc, out_inst,
        input  imem_inst, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_addr, out_valid, out_pc, out_inst,
        output imem_inst, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: RV32 instruction fetch. Owns the PC, drives the synchronous
// instruction ROM address, captures the returned word one cycle later and
// presents {pc, inst} to decode through a 2-entry buffer.
// Ports:
//   clk  - clock
//   rst  - synchronous reset, active low
//   bus  - fetch_if.master (ROM port, redirect input, decode handshake)
// Parameter RESET_PC: first fetch address after reset (word aligned).
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic clk,
    input  logic rst,
    fetch_if.master bus
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fentry_t;

    logic [31:0] fetch_pc_q;
    logic        inflight_q;
    logic [31:0] inflight_pc_q;
    logic [1:0]  count_q, count_d;
    fentry_t     fifo_q [2];
    fentry_t     fifo_d [2];

    logic        redir, pop, push, issue;
    logic [2:0]  occ;
    logic [1:0]  cnt_after;
    logic [31:0] addr;

    // Redirect has no effect while reset is held.
    assign redir = rst & bus.redirect_valid;
    assign pop   = (count_q != 2'd0) & bus.out_ready;
    assign push  = inflight_q & ~redir;

    // Occupancy the buffer will have once this cycle's pop and the in-flight
    // word are accounted for; issuing only while it is <= 1 guarantees a
    // free slot when the new response lands, so the buffer never overflows.
    assign occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue = redir | (occ <= 3'd1);

    always_comb begin
        addr = fetch_pc_q;
        if (!rst)
            addr = RESET_PC;
        else if (redir)
            addr = bus.redirect_pc & ~32'h3;
    end

    assign bus.imem_addr = addr;

    // Shift-register buffer: slot 0 is always the head, so outputs come
    // straight from flops.
    always_comb begin
        fifo_d    = fifo_q;
        count_d   = count_q;
        cnt_after = count_q - {1'b0, pop};
        if (redir) begin
            count_d = 2'd0;
        end else begin
            if (pop)
                fifo_d[0] = fifo_q[1];
            // cnt_after <= 1 whenever a push happens, so bit 0 picks the slot.
            if (push)
                fifo_d[cnt_after[0]] = '{pc: inflight_pc_q, inst: bus.imem_inst};
            count_d = cnt_after + {1'b0, push};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0;
            count_q       <= 2'd0;
            fifo_q[0]     <= '0;
            fifo_q[1]     <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= addr;
                fetch_pc_q    <= addr + 32'd4;
            end
            count_q <= count_d;
            fifo_q  <= fifo_d;
        end
    end

    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_pc    = fifo_q[0].pc;
    assign bus.out_inst  = fifo_q[0].inst;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table for reset/stream/stall/redirect,
// hand sequences for reset-time wrap, and a randomised scoreboard run.
module tb_fetch_stage;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_if ia ();
    fetch_if ib ();

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut_a (.clk(clk), .rst(rst), .bus(ia.master));
    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_b (.clk(clk), .rst(rst), .bus(ib.master));

    // ROM model: word k holds 0x1000_0000 + k.
    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    always @(posedge clk) begin
        ia.imem_inst <= rom(ia.imem_addr);
        ib.imem_inst <= rom(ib.imem_addr);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // chk: 0 = no check, 1 = valid/addr/pc/inst, 2 = valid/addr only
    typedef struct {
        logic        rst, rdy, rv;
        logic [31:0] rpc;
        int          chk;
        logic        ev;
        logic [31:0] epc, einst, eaddr;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc,
                       input int c, input logic ev, input logic [31:0] pc,
                       input logic [31:0] inst, input logic [31:0] addr);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.chk = c;
        v.ev = ev; v.epc = pc; v.einst = inst; v.eaddr = addr;
        vq.push_back(v);
    endtask

    logic        rdy, rv, prev_rv, hold;
    logic [31:0] rpc, exp_pc, hpc, hinst;
    int          pops;
    logic [31:0] wrap_pc [4];

    initial begin
        ia.out_ready = 1'b0; ia.redirect_valid = 1'b0; ia.redirect_pc = 32'h0;
        ib.out_ready = 1'b1; ib.redirect_valid = 1'b0; ib.redirect_pc = 32'h0;

        // ---- stream start + stall (cycles 0..13) ----
        add(1,1,0,0, 1, 0, 32'h0,  32'h0,          32'h0);
        add(1,1,0,0, 1, 0, 32'h0,  32'h0,          32'h4);
        add(1,1,0,0, 1, 1, 32'h0,  rom(32'h0),     32'h8);
        add(1,1,0,0, 1, 1, 32'h4,  rom(32'h4),     32'hC);
        for (int i = 0; i < 5; i++)
            add(1,0,0,0, 1, 1, 32'h8, rom(32'h8),  32'h10);
        add(1,1,0,0, 1, 1, 32'h8,  rom(32'h8),     32'h10);
        add(1,1,0,0, 1, 1, 32'hC,  rom(32'hC),     32'h14);
        add(1,1,0,0, 1, 1, 32'h10, rom(32'h10),    32'h18);
        add(1,1,0,0, 1, 1, 32'h14, rom(32'h14),    32'h1C);
        add(1,0,0,0, 1, 1, 32'h18, rom(32'h18),    32'h20);   // buffer fills
        // ---- one-cycle reset with a full buffer ----
        add(0,0,0,0, 0, 0, 32'h0,  32'h0,          32'h0);
        // ---- restart, redirect to 0x43 at restart cycle 6 ----
        add(1,1,0,0, 1, 0, 32'h0,  32'h0,          32'h0);
        add(1,1,0,0, 1, 0, 32'h0,  32'h0,          32'h4);
        add(1,1,0,0, 1, 1, 32'h0,  rom(32'h0),     32'h8);
        add(1,1,0,0, 1, 1, 32'h4,  rom(32'h4),     32'hC);
        add(1,1,0,0, 1, 1, 32'h8,  rom(32'h8),     32'h10);
        add(1,1,0,0, 1, 1, 32'hC,  rom(32'hC),     32'h14);
        add(1,1,1,32'h43, 1, 1, 32'h10, rom(32'h10), 32'h40);
        add(1,1,0,0, 2, 0, 32'h0,  32'h0,          32'h44);
        add(1,1,0,0, 1, 1, 32'h40, 32'h1000_0010,  32'h48);
        add(1,1,0,0, 1, 1, 32'h44, 32'h1000_0011,  32'h4C);
        // ---- back-to-back redirects: last one wins ----
        add(1,1,1,32'h100, 1, 1, 32'h48, rom(32'h48), 32'h100);
        add(1,1,1,32'h203, 2, 0, 32'h0,  32'h0,       32'h200);
        add(1,1,0,0, 2, 0, 32'h0,  32'h0,          32'h204);
        add(1,1,0,0, 1, 1, 32'h200, rom(32'h200),  32'h208);
        add(1,1,0,0, 1, 1, 32'h204, rom(32'h204),  32'h20C);
        // ---- redirect while stalled with a full buffer ----
        add(1,0,0,0, 1, 1, 32'h208, rom(32'h208),  32'h210);
        add(1,0,0,0, 1, 1, 32'h208, rom(32'h208),  32'h210);
        add(1,0,1,32'h300, 1, 1, 32'h208, rom(32'h208), 32'h300);
        add(1,1,0,0, 2, 0, 32'h0,  32'h0,          32'h304);
        add(1,1,0,0, 1, 1, 32'h300, 32'h1000_00C0, 32'h308);

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < vq.size(); i++) begin
            rst = vq[i].rst;
            ia.out_ready = vq[i].rdy;
            ia.redirect_valid = vq[i].rv;
            ia.redirect_pc = vq[i].rpc;
            @(negedge clk);
            if (vq[i].chk >= 1) begin
                chk32($sformatf("vec%0d_valid", i), {31'b0, ia.out_valid}, {31'b0, vq[i].ev});
                chk32($sformatf("vec%0d_addr", i), ia.imem_addr, vq[i].eaddr);
            end
            if (vq[i].chk == 1) begin
                chk32($sformatf("vec%0d_pc", i), ia.out_pc, vq[i].epc);
                chk32($sformatf("vec%0d_inst", i), ia.out_inst, vq[i].einst);
            end
            @(posedge clk);
            #1;
        end

        // ---- reset-held outputs, then RESET_PC wrap on the second instance ----
        rst = 1'b0; ia.redirect_valid = 1'b1; ia.redirect_pc = 32'h500; ia.out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk32("rst_held_valid", {31'b0, ia.out_valid}, 32'h0);
        chk32("rst_held_pc", ia.out_pc, 32'h0);
        chk32("rst_held_inst", ia.out_inst, 32'h0);
        chk32("rst_held_addr", ia.imem_addr, 32'h0);
        chk32("rst_held_addr_b", ib.imem_addr, 32'hFFFF_FFF8);
        @(posedge clk); #1;
        rst = 1'b1; ia.redirect_valid = 1'b0;
        wrap_pc[0] = 32'hFFFF_FFF8; wrap_pc[1] = 32'hFFFF_FFFC;
        wrap_pc[2] = 32'h0000_0000; wrap_pc[3] = 32'h0000_0004;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c < 2) begin
                chk32($sformatf("wrap_c%0d_valid", c), {31'b0, ib.out_valid}, 32'h0);
            end else begin
                chk32($sformatf("wrap_c%0d_valid", c), {31'b0, ib.out_valid}, 32'h1);
                chk32($sformatf("wrap_c%0d_pc", c), ib.out_pc, wrap_pc[c-2]);
                chk32($sformatf("wrap_c%0d_inst", c), ib.out_inst, rom(wrap_pc[c-2]));
            end
            @(posedge clk); #1;
        end

        // ---- random ready + random redirects, scoreboard on dut_a ----
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_pc = 32'h0; prev_rv = 1'b0; hold = 1'b0; pops = 0; hpc = 0; hinst = 0;
        for (int c = 0; c < 4000; c++) begin
            rdy = 1'($urandom_range(0, 1));
            rv  = ($urandom_range(0, 11) == 0);
            rpc = $urandom;
            ia.out_ready = rdy; ia.redirect_valid = rv; ia.redirect_pc = rpc;
            @(negedge clk);
            if (prev_rv)
                chk32("rnd_flush_valid", {31'b0, ia.out_valid}, 32'h0);
            if (hold) begin
                chk32("rnd_hold_valid", {31'b0, ia.out_valid}, 32'h1);
                chk32("rnd_hold_pc", ia.out_pc, hpc);
                chk32("rnd_hold_inst", ia.out_inst, hinst);
            end
            if (ia.out_valid && rdy) begin
                chk32("rnd_pc", ia.out_pc, exp_pc);
                chk32("rnd_inst", ia.out_inst, rom(exp_pc));
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (rv)
                exp_pc = rpc & ~32'h3;
            hold = ia.out_valid & ~rdy & ~rv;
            hpc = ia.out_pc; hinst = ia.out_inst;
            prev_rv = rv;
            @(posedge clk);
            #1;
        end
        chk32("rnd_progress", {31'b0, (pops >= 800)}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
